gray_monitor: RTL and testbench

Downstream checker/extender for the 3-bit Gray step counter (outputs Gray[2:0] plus sticky Overflow). Each cycle it samples the counter outputs and does four jobs: decodes Gray to binary, checks that every change is a legal single forward step, checks that Overflow agrees with the 7->0 wrap, and extends the count into a W-bit total. Errors are latched with a code and cleared by a handshake that resynchronises to the counter's current value.

---
 rtl/gray_monitor.sv | 119 +++++++++++
 tb/tb_gray_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_monitor.sv
// Checks and extends a 3-bit Gray step counter: decode, step/overflow checking,
// W-bit extended count, latched error code with a clear/resync handshake.
module gray_monitor #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [2:0]   Gray,
  input  logic         Ovf,
  input  logic         Clear,
  output logic [2:0]   Bin,
  output logic [W-1:0] Total,
  output logic         Step,
  output logic         Err,
  output logic [1:0]   ErrCode
);

  typedef enum logic [1:0] {TRACK, ERROR, RESYNC} state_t;

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CODE_MISSING  = 2'b10;
  localparam logic [1:0] CODE_SPURIOUS = 2'b11;

  function automatic logic [2:0] decode(input logic [2:0] g);
    return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

  state_t       state, state_nxt;
  logic [2:0]   prev_gray, pg_nxt;
  logic         prev_ovf, po_nxt;
  logic [W-1:0] total_nxt;
  logic         step_nxt, err_nxt;
  logic [1:0]   code_nxt, cls;
  logic [2:0]   cur, prv, diff;
  logic         one_bit, fwd, wrap;

  assign cur     = decode(Gray);
  assign prv     = decode(prev_gray);
  assign diff    = Gray ^ prev_gray;
  assign one_bit = (diff != 3'd0) && ((diff & (diff - 3'd1)) == 3'd0);
  assign fwd     = (cur == prv + 3'd1);
  assign wrap    = (prv == 3'd7) && (cur == 3'd0);

  always_comb begin
    state_nxt = state;
    pg_nxt    = prev_gray;
    po_nxt    = prev_ovf;
    total_nxt = Total;
    step_nxt  = 1'b0;
    err_nxt   = Err;
    code_nxt  = ErrCode;
    cls       = CODE_NONE;
    unique case (state)
      TRACK: begin
        pg_nxt = Gray;
        po_nxt = Ovf;
        // Ovf falling at Gray 0 means the upstream counter was reset
        if (prev_ovf && !Ovf && Gray == 3'd0) begin
          total_nxt = '0;
        end else if (prev_ovf && !Ovf) begin
          cls = CODE_ILLEGAL;
        end else if (Gray == prev_gray && Ovf == prev_ovf) begin
          total_nxt = Total;
        end else if (!one_bit || !fwd) begin
          cls = CODE_ILLEGAL;
        end else if (wrap && !Ovf) begin
          cls = CODE_MISSING;
        end else if (!prev_ovf && Ovf && !wrap) begin
          cls = CODE_SPURIOUS;
        end else begin
          total_nxt = Total + W'(1);
          step_nxt  = 1'b1;
        end
        if (cls != CODE_NONE) begin
          state_nxt = ERROR;
          total_nxt = Total;
          err_nxt   = 1'b1;
          code_nxt  = cls;
        end
      end
      ERROR: begin
        if (Clear) state_nxt = RESYNC;
      end
      RESYNC: begin
        pg_nxt    = Gray;
        po_nxt    = Ovf;
        err_nxt   = 1'b0;
        code_nxt  = CODE_NONE;
        total_nxt = {{(W-3){1'b0}}, cur};
        state_nxt = TRACK;
      end
      default: state_nxt = TRACK;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= TRACK;
      prev_gray <= 3'd0;
      prev_ovf  <= 1'b0;
      Bin       <= 3'd0;
      Total     <= '0;
      Step      <= 1'b0;
      Err       <= 1'b0;
      ErrCode   <= CODE_NONE;
    end else begin
      state     <= state_nxt;
      prev_gray <= pg_nxt;
      prev_ovf  <= po_nxt;
      Bin       <= cur;
      Total     <= total_nxt;
      Step      <= step_nxt;
      Err       <= err_nxt;
      ErrCode   <= code_nxt;
    end
  end

endmodule

// File: tb/tb_gray_monitor.sv
// Bench for gray_monitor: directed vector table, W=4 wrap sequence, and
// randomized stimulus against a sequence-table reference model.
module tb_gray_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] gray = 3'd0;
  logic       ovf = 1'b0;
  logic       clear = 1'b0;

  logic [2:0] bin8, bin4;
  logic [7:0] tot8;
  logic [3:0] tot4;
  logic       step8, step4, err8, err4;
  logic [1:0] code8, code4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gray_monitor #(.W(8)) dut8 (
    .Clk(clk), .Reset(reset), .Gray(gray), .Ovf(ovf), .Clear(clear),
    .Bin(bin8), .Total(tot8), .Step(step8), .Err(err8), .ErrCode(code8)
  );

  gray_monitor #(.W(4)) dut4 (
    .Clk(clk), .Reset(reset), .Gray(gray), .Ovf(ovf), .Clear(clear),
    .Bin(bin4), .Total(tot4), .Step(step4), .Err(err4), .ErrCode(code4)
  );

  // Counter sequence: position i holds the Gray code of binary value i
  logic [2:0] seq [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  function automatic int g2b(input logic [2:0] g);
    for (int i = 0; i < 8; i++) if (seq[i] == g) return i;
    return 0;
  endfunction

  // Reference model: 0 tracking, 1 error, 2 resync
  int         m_mode = 0;
  logic [2:0] m_pg = 3'd0;
  logic       m_po = 1'b0;
  logic [2:0] m_bin = 3'd0;
  logic [7:0] m_total = 8'd0;
  logic       m_step = 1'b0, m_err = 1'b0;
  logic [1:0] m_code = 2'd0;

  task automatic model_update(input logic [2:0] g, input logic o, input logic c, input logic r);
    int cur, prv;
    logic [1:0] code;
    cur = g2b(g);
    prv = g2b(m_pg);
    if (r) begin
      m_mode = 0; m_pg = 0; m_po = 0; m_bin = 0; m_total = 0;
      m_step = 0; m_err = 0; m_code = 0;
      return;
    end
    m_bin  = 3'(cur);
    m_step = 1'b0;
    code   = 2'd0;
    case (m_mode)
      0: begin
        if (m_po && !o && g == 3'd0) m_total = 0;
        else if (m_po && !o) code = 2'd1;
        else if (g == m_pg && o == m_po) ;
        else if ($countones(g ^ m_pg) != 1 || cur != (prv + 1) % 8) code = 2'd1;
        else if (prv == 7 && cur == 0 && !o) code = 2'd2;
        else if (!m_po && o && !(prv == 7 && cur == 0)) code = 2'd3;
        else begin m_total = m_total + 8'd1; m_step = 1'b1; end
        if (code != 0) begin m_mode = 1; m_err = 1; m_code = code; end
        m_pg = g; m_po = o;
      end
      1: if (c) m_mode = 2;
      default: begin
        m_err = 0; m_code = 0; m_total = 8'(cur);
        m_pg = g; m_po = o; m_mode = 0;
      end
    endcase
  endtask

  task automatic check_model();
    tests++;
    if ({bin8, tot8, step8, err8, code8} !== {m_bin, m_total, m_step, m_err, m_code}) begin
      fails++;
      $display("FAIL model_w8 t=%0t got bin=%0d tot=%0d step=%0b err=%0b code=%0d want bin=%0d tot=%0d step=%0b err=%0b code=%0d",
               $time, bin8, tot8, step8, err8, code8, m_bin, m_total, m_step, m_err, m_code);
    end
    tests++;
    if ({bin4, tot4, step4, err4, code4} !== {m_bin, m_total[3:0], m_step, m_err, m_code}) begin
      fails++;
      $display("FAIL model_w4 t=%0t got bin=%0d tot=%0d step=%0b err=%0b code=%0d want bin=%0d tot=%0d step=%0b err=%0b code=%0d",
               $time, bin4, tot4, step4, err4, code4, m_bin, m_total[3:0], m_step, m_err, m_code);
    end
  endtask

  task automatic cyc(input logic [2:0] g, input logic o, input logic c, input logic r);
    gray = g; ovf = o; clear = c; reset = r;
    @(posedge clk);
    model_update(g, o, c, r);
    #1;
    check_model();
  endtask

  typedef struct {
    logic [2:0] g;
    logic       o, c, r;
    logic [2:0] bin;
    logic [7:0] tot;
    logic       s, e;
    logic [1:0] code;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] g, input logic o, input logic c, input logic r,
                     input logic [2:0] b, input logic [7:0] t, input logic s,
                     input logic e, input logic [1:0] k);
    vec_t v;
    v.g = g; v.o = o; v.c = c; v.r = r;
    v.bin = b; v.tot = t; v.s = s; v.e = e; v.code = k;
    vecs.push_back(v);
  endtask

  initial begin
    logic [2:0] g, nl;
    logic       o, c, r, wrap;
    int         sel;

    //  g  o  c  r   bin tot s e code
    add(0, 0, 0, 1,  0,  0, 0, 0, 0);   // reset
    add(0, 0, 0, 0,  0,  0, 0, 0, 0);
    add(1, 0, 0, 0,  1,  1, 1, 0, 0);
    add(3, 0, 0, 0,  2,  2, 1, 0, 0);
    add(2, 0, 0, 0,  3,  3, 1, 0, 0);
    add(6, 0, 0, 0,  4,  4, 1, 0, 0);
    add(7, 0, 0, 0,  5,  5, 1, 0, 0);
    add(5, 0, 0, 0,  6,  6, 1, 0, 0);
    add(4, 0, 0, 0,  7,  7, 1, 0, 0);
    add(0, 1, 0, 0,  0,  8, 1, 0, 0);   // wrap with Ovf rising
    add(1, 1, 0, 0,  1,  9, 1, 0, 0);
    add(3, 1, 0, 0,  2, 10, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(3, 1, 0, 0, 2, 10, 0, 0, 0);  // hold
    add(0, 0, 0, 0,  0,  0, 0, 0, 0);   // upstream reset
    add(1, 0, 1, 0,  1,  1, 1, 0, 0);   // Clear ignored in tracking
    add(0, 0, 0, 1,  0,  0, 0, 0, 0);
    add(3, 0, 0, 0,  2,  0, 0, 1, 1);   // 0 -> 2 illegal
    add(3, 0, 0, 0,  2,  0, 0, 1, 1);
    add(3, 0, 1, 0,  2,  0, 0, 1, 1);   // clear -> resync
    add(3, 0, 0, 0,  2,  2, 0, 0, 0);   // resync loads decode
    add(2, 0, 0, 0,  3,  3, 1, 0, 0);
    add(6, 0, 0, 0,  4,  4, 1, 0, 0);
    add(7, 0, 0, 0,  5,  5, 1, 0, 0);
    add(5, 0, 0, 0,  6,  6, 1, 0, 0);
    add(4, 0, 0, 0,  7,  7, 1, 0, 0);
    add(0, 0, 0, 0,  0,  7, 0, 1, 2);   // wrap without Ovf
    add(1, 1, 0, 0,  1,  7, 0, 1, 2);   // first code kept
    add(0, 0, 1, 0,  0,  7, 0, 1, 2);
    add(0, 0, 0, 0,  0,  0, 0, 0, 0);
    add(1, 0, 0, 0,  1,  1, 1, 0, 0);
    add(3, 1, 0, 0,  2,  1, 0, 1, 3);   // spurious Ovf
    add(3, 1, 0, 1,  0,  0, 0, 0, 0);   // reset in error
    add(1, 0, 0, 0,  1,  1, 1, 0, 0);
    add(1, 1, 0, 0,  1,  1, 0, 1, 1);   // Ovf rise with no step

    foreach (vecs[i]) begin
      cyc(vecs[i].g, vecs[i].o, vecs[i].c, vecs[i].r);
      tests++;
      if ({bin8, tot8, step8, err8, code8} !== {vecs[i].bin, vecs[i].tot, vecs[i].s, vecs[i].e, vecs[i].code}) begin
        fails++;
        $display("FAIL vec%0d got bin=%0d tot=%0d step=%0b err=%0b code=%0d want bin=%0d tot=%0d step=%0b err=%0b code=%0d",
                 i, bin8, tot8, step8, err8, code8, vecs[i].bin, vecs[i].tot, vecs[i].s, vecs[i].e, vecs[i].code);
      end
      tests++;
      if (tot4 !== vecs[i].tot[3:0]) begin
        fails++;
        $display("FAIL vec%0d_w4 got tot=%0d want tot=%0d", i, tot4, vecs[i].tot[3:0]);
      end
    end

    // 16 legal steps: W=4 total wraps back to 0
    cyc(0, 0, 0, 1);
    for (int k = 1; k <= 16; k++) cyc(seq[k % 8], (k >= 8), 0, 0);
    tests++;
    if (tot4 !== 4'd0 || tot8 !== 8'd16 || err4 !== 1'b0 || err8 !== 1'b0) begin
      fails++;
      $display("FAIL wrap16 got tot4=%0d tot8=%0d err4=%0b err8=%0b want 0 16 0 0", tot4, tot8, err4, err8);
    end

    // Ovf falling with nonzero Gray
    cyc(1, 0, 0, 0);
    tests++;
    if (err8 !== 1'b1 || code8 !== 2'd1) begin
      fails++;
      $display("FAIL ovf_fall got err=%0b code=%0d want 1 1", err8, code8);
    end

    for (int n = 0; n < 3000; n++) begin
      nl   = seq[(g2b(m_pg) + 1) % 8];
      wrap = (g2b(m_pg) == 7);
      sel  = $urandom_range(99);
      if (sel < 55)      begin g = nl;   o = m_po | wrap; end
      else if (sel < 70) begin g = m_pg; o = m_po; end
      else if (sel < 80) begin g = 3'($urandom_range(7)); o = m_po; end
      else if (sel < 88) begin g = nl;   o = ~(m_po | wrap); end
      else if (sel < 92) begin g = 3'd0; o = 1'b0; end
      else               begin g = 3'($urandom_range(7)); o = 1'($urandom_range(1)); end
      c = ($urandom_range(3) == 0);
      r = ($urandom_range(199) == 0);
      cyc(g, o, c, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
